// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD host: command codes, image geometry and
// the host sequencing states.
package lcd_pkg;

  localparam int IMG_PIX = 64;
  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 6;
  localparam int CMD_W   = 4;
  // 64 x 255 = 16320 fits in 14 bits, so the frame sum never wraps.
  localparam int SUM_W   = 14;

  typedef enum logic [CMD_W-1:0] {
    CMD_WRITE    = 4'd0,
    CMD_UP       = 4'd1,
    CMD_DOWN     = 4'd2,
    CMD_LEFT     = 4'd3,
    CMD_RIGHT    = 4'd4,
    CMD_MAX      = 4'd5,
    CMD_MIN      = 4'd6,
    CMD_AVG      = 4'd7,
    CMD_ROT_CCW  = 4'd8,
    CMD_ROT_CW   = 4'd9,
    CMD_MIRROR_X = 4'd10,
    CMD_MIRROR_Y = 4'd11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_CAPTURE,
    ST_FIN
  } host_state_e;

endpackage

// File: rtl/lcd_host_if.sv
// Pin bundle between the host and the LCD controller. The master modport
// is the host side; the slave modport is the controller side.
interface lcd_host_if;
  import lcd_pkg::*;

  logic [CMD_W-1:0]  cmd;
  logic              cmd_valid;
  logic              busy;
  logic              IROM_rd;
  logic [ADDR_W-1:0] IROM_A;
  logic [PIX_W-1:0]  IROM_Q;
  logic              IRAM_valid;
  logic [ADDR_W-1:0] IRAM_A;
  logic [PIX_W-1:0]  IRAM_D;
  logic              done;

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  busy, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, done
  );

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output busy, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, done
  );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command queue. Pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter. A push into a full
// queue is still taken when a pop happens in the same cycle.
module lcd_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Storage write; when full the write slot equals the read slot, but the
  // head is read combinationally before the edge so both operations hold.
  // NOTE: storage has no reset -- contents are meaningless until the
  // pointers say so, and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
  end

  // Pointer advance.
  // NOTE: state registers use <= so every flop samples pre-edge values,
  // independent of the order blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_host.sv
// Host side of the LCD image controller: serves image-ROM reads from a
// loadable store, issues queued commands with a one-cycle gap after each,
// and captures the write-back frame while summing its bytes.
module lcd_host
  import lcd_pkg::*;
#(
  parameter int CQ_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  lcd_host_if.master        ctl,
  input  logic              img_we,
  input  logic [ADDR_W-1:0] img_addr,
  input  logic [PIX_W-1:0]  img_data,
  input  logic              cq_push,
  input  logic [CMD_W-1:0]  cq_data,
  output logic              cq_full,
  input  logic              start,
  input  logic [ADDR_W-1:0] cap_addr,
  output logic [PIX_W-1:0]  cap_data,
  output logic              frame_done,
  output logic [SUM_W-1:0]  checksum,
  output logic              overflow
);

  host_state_e      state_q, state_d;
  logic [CMD_W-1:0] head, cmd_q, cmd_d;
  logic             fifo_empty;
  logic             issue;
  logic             overflow_q, overflow_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] checksum_q, checksum_d;
  logic [PIX_W-1:0] rom_q [IMG_PIX];
  logic [PIX_W-1:0] cap_q [IMG_PIX];

  lcd_cmd_fifo #(
    .DEPTH (CQ_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (cq_push),
    .pop_i   (issue),
    .data_i  (cq_data),
    .data_o  (head),
    .full_o  (cq_full),
    .empty_o (fifo_empty)
  );

  // Sequencing: issue in RUN when the controller is idle, then either pause
  // one cycle (GAP) so a calc command's busy becomes visible, or switch to
  // capturing the write-back frame.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (!ctl.busy && !fifo_empty) begin
          issue   = 1'b1;
          state_d = (head == CMD_WRITE) ? ST_CAPTURE : ST_GAP;
        end
      end
      ST_GAP:     state_d = ST_RUN;
      ST_CAPTURE: if (ctl.done) state_d = ST_FIN;
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: held command, sticky overflow, frame accumulator
  // (cleared on entry to CAPTURE) and the checksum latched on done, which
  // includes any write arriving in that same cycle.
  always_comb begin
    cmd_d      = issue ? head : cmd_q;
    overflow_d = overflow_q | (cq_push & cq_full & ~issue);
    acc_d      = acc_q;
    checksum_d = checksum_q;
    if (issue && head == CMD_WRITE) begin
      acc_d = '0;
    end else if (state_q == ST_CAPTURE && ctl.IRAM_valid) begin
      acc_d = acc_q + SUM_W'(ctl.IRAM_D);
    end
    if (state_q == ST_CAPTURE && ctl.done) checksum_d = acc_d;
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      overflow_q <= 1'b0;
      acc_q      <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      overflow_q <= overflow_d;
      acc_q      <= acc_d;
      checksum_q <= checksum_d;
    end
  end

  // Image store load, honoured only while idle.
  always_ff @(posedge clk) begin
    if (img_we && state_q == ST_IDLE) rom_q[img_addr] <= img_data;
  end

  // Write-back capture array.
  always_ff @(posedge clk) begin
    if (state_q == ST_CAPTURE && ctl.IRAM_valid) cap_q[ctl.IRAM_A] <= ctl.IRAM_D;
  end

  assign ctl.cmd       = cmd_d;
  assign ctl.cmd_valid = issue;
  assign ctl.IROM_Q    = ctl.IROM_rd ? rom_q[ctl.IROM_A] : '0;
  assign cap_data      = cap_q[cap_addr];
  assign frame_done    = (state_q == ST_FIN);
  assign checksum      = checksum_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_lcd_host.sv
// Bench for lcd_host. The main process plays loader and controller; a
// monitor compares every command strobe and frame completion against
// expectations queued by the stimulus, using a queue-and-array model.
module tb_lcd_host;
  import lcd_pkg::*;

  localparam int CQ_DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              img_we;
  logic [ADDR_W-1:0] img_addr;
  logic [PIX_W-1:0]  img_data;
  logic              cq_push;
  logic [CMD_W-1:0]  cq_data;
  logic              cq_full;
  logic              start;
  logic [ADDR_W-1:0] cap_addr;
  logic [PIX_W-1:0]  cap_data;
  logic              frame_done;
  logic [SUM_W-1:0]  checksum;
  logic              overflow;

  lcd_host_if ifc ();

  lcd_host #(.CQ_DEPTH(CQ_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .ctl        (ifc),
    .img_we     (img_we),
    .img_addr   (img_addr),
    .img_data   (img_data),
    .cq_push    (cq_push),
    .cq_data    (cq_data),
    .cq_full    (cq_full),
    .start      (start),
    .cap_addr   (cap_addr),
    .cap_data   (cap_data),
    .frame_done (frame_done),
    .checksum   (checksum),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  logic [CMD_W-1:0] exp_q [$];   // commands the host still owes, in order
  logic [SUM_W-1:0] sum_q [$];   // checksums owed at frame completion
  logic [PIX_W-1:0] rom_m [IMG_PIX];
  logic [PIX_W-1:0] cap_m [IMG_PIX];
  logic             ovf_m;
  int               strobe_log [$];
  int               cyc = 0;
  int               last_strobe = -100;
  int               busy_left = 0;
  int               calc_len = 0;
  bit               cap_mode = 1'b0;
  bit               fd_prev = 1'b0;
  bit               chk_rom = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Controller busy: after a calc strobe, hold busy for calc_len cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (busy_left > 0) begin
        ifc.busy = 1'b1;
        busy_left--;
      end else begin
        ifc.busy = 1'b0;
      end
    end
  end

  // Monitor: compares DUT outputs against the queued expectations.
  always @(negedge clk) begin
    logic [CMD_W-1:0] e;
    if (reset) begin
      if (ifc.cmd_valid) begin
        check("strobe_while_busy", 32'(ifc.busy), 32'(0));
        check("strobe_in_capture", 32'(cap_mode), 32'(0));
        check("issue_spacing", 32'(cyc - last_strobe >= 2), 32'(1));
        if (exp_q.size() == 0) begin
          fail_evt("spurious_cmd");
        end else begin
          e = exp_q.pop_front();
          check("cmd", 32'(ifc.cmd), 32'(e));
          if (e == 4'(CMD_WRITE)) cap_mode = 1'b1;
          if (e >= 4'(CMD_MAX) && e <= 4'(CMD_AVG)) busy_left = calc_len;
        end
        strobe_log.push_back(cyc);
        last_strobe = cyc;
      end
      if (frame_done) begin
        check("frame_done_width", 32'(fd_prev), 32'(0));
        if (sum_q.size() == 0) fail_evt("spurious_frame_done");
        else check("checksum", 32'(checksum), 32'(sum_q.pop_front()));
        cap_mode = 1'b0;
      end
      fd_prev = frame_done;
      if (chk_rom)
        check("irom_q", 32'(ifc.IROM_Q),
              32'(ifc.IROM_rd ? rom_m[ifc.IROM_A] : 8'h00));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [CMD_W-1:0] c);
    cq_push = 1'b1;
    cq_data = c;
    if (exp_q.size() < CQ_DEPTH) exp_q.push_back(c);
    else ovf_m = 1'b1;
    tick();
    cq_push = 1'b0;
  endtask

  // Push in a cycle where the DUT is known to pop: accepted even if full.
  task automatic push_forced(input logic [CMD_W-1:0] c);
    cq_push = 1'b1;
    cq_data = c;
    exp_q.push_back(c);
    tick();
    cq_push = 1'b0;
  endtask

  task automatic start_pulse(output int s);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    tick();
    check({"drain_", name}, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic wait_cap(input string name, input int max);
    int n = 0;
    while (!cap_mode && n < max) begin
      tick();
      n++;
    end
    check({"capture_entered_", name}, 32'(cap_mode), 32'(1));
  endtask

  // Controller write-back: all 64 addresses in random order, random idle
  // gaps, done raised together with the final write.
  task automatic do_frame(input bit all_ff, input int n_writes, input bit finish);
    int perm [IMG_PIX];
    int j, t;
    logic [SUM_W-1:0] sum = '0;
    logic [PIX_W-1:0] d;
    for (int i = 0; i < IMG_PIX; i++) perm[i] = i;
    for (int i = IMG_PIX - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < n_writes; i++) begin
      ifc.IRAM_valid = 1'b0;
      if ($urandom_range(3, 0) == 0) tick();
      d = all_ff ? 8'hFF : 8'($urandom);
      ifc.IRAM_valid = 1'b1;
      ifc.IRAM_A = 6'(perm[i]);
      ifc.IRAM_D = d;
      cap_m[perm[i]] = d;
      sum = sum + SUM_W'(d);
      if (finish && i == n_writes - 1) begin
        ifc.done = 1'b1;
        sum_q.push_back(sum);
      end
      tick();
      ifc.done = 1'b0;
    end
    ifc.IRAM_valid = 1'b0;
    if (finish) begin
      repeat (3) tick();
      check("frame_done_seen", 32'(sum_q.size()), 32'(0));
    end
  endtask

  task automatic check_cap(input int a);
    cap_addr = 6'(a);
    #1;
    check("cap_data", 32'(cap_data), 32'(cap_m[a]));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd"},        32'(ifc.cmd),       32'(0));
    check({tag, "_cmd_valid"},  32'(ifc.cmd_valid), 32'(0));
    check({tag, "_irom_q"},     32'(ifc.IROM_Q),    32'(0));
    check({tag, "_cq_full"},    32'(cq_full),       32'(0));
    check({tag, "_frame_done"}, 32'(frame_done),    32'(0));
    check({tag, "_checksum"},   32'(checksum),      32'(0));
    check({tag, "_overflow"},   32'(overflow),      32'(ovf_m));
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    exp_q.delete();
    sum_q.delete();
    cap_mode = 1'b0;
    busy_left = 0;
    fd_prev = 1'b0;
    ovf_m = 1'b0;
    ifc.IRAM_valid = 1'b0;
    ifc.done = 1'b0;
    repeat (2) tick();
  endtask

  // Watchdog: the bench must always terminate.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int d0, d1;
    logic [PIX_W-1:0] old5;
    logic [CMD_W-1:0] c;

    img_we = 1'b0; img_addr = '0; img_data = '0;
    cq_push = 1'b0; cq_data = '0; start = 1'b0; cap_addr = '0;
    ifc.busy = 1'b0; ifc.IROM_rd = 1'b0; ifc.IROM_A = '0;
    ifc.IRAM_valid = 1'b0; ifc.IRAM_A = '0; ifc.IRAM_D = '0; ifc.done = 1'b0;

    // Reset state.
    apply_reset();
    check_reset("reset");
    reset = 1'b1;
    tick();

    // Image store: identity load, sequential reads, then reads disabled.
    for (int i = 0; i < IMG_PIX; i++) begin
      img_we = 1'b1; img_addr = 6'(i); img_data = 8'(i); rom_m[i] = 8'(i);
      tick();
    end
    img_we = 1'b0;
    chk_rom = 1'b1;
    ifc.IROM_rd = 1'b1;
    for (int i = 0; i < IMG_PIX; i++) begin
      ifc.IROM_A = 6'(i);
      tick();
    end
    ifc.IROM_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifc.IROM_A = 6'($urandom);
      tick();
    end

    // Random image, random read pattern.
    for (int i = 0; i < IMG_PIX; i++) begin
      img_we = 1'b1; img_addr = 6'(i); img_data = 8'($urandom); rom_m[i] = img_data;
      tick();
    end
    img_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ifc.IROM_rd = 1'($urandom);
      ifc.IROM_A = 6'($urandom);
      tick();
    end
    ifc.IROM_rd = 1'b0;

    // Shift/rotate burst with busy low: strobes exactly two cycles apart.
    calc_len = 0;
    strobe_log.delete();
    push_cmd(4'(CMD_RIGHT));
    push_cmd(4'(CMD_RIGHT));
    push_cmd(4'(CMD_ROT_CCW));
    start_pulse(s);
    wait_drain("burst", 20);
    check("burst_count", 32'(strobe_log.size()), 32'(3));
    if (strobe_log.size() == 3) begin
      check("burst_latency", 32'(strobe_log[0] - s), 32'(1));
      check("burst_gap0", 32'(strobe_log[1] - strobe_log[0]), 32'(2));
      check("burst_gap1", 32'(strobe_log[2] - strobe_log[1]), 32'(2));
    end
    check("cmd_hold", 32'(ifc.cmd), 32'(CMD_ROT_CCW));
    check("cmd_valid_idle", 32'(ifc.cmd_valid), 32'(0));

    // Calc command holds busy for 5 cycles; next command waits for it.
    calc_len = 5;
    strobe_log.delete();
    push_cmd(4'(CMD_AVG));
    push_cmd(4'(CMD_UP));
    wait_drain("calc", 40);
    d0 = (strobe_log.size() == 2) ? strobe_log[1] - strobe_log[0] : -1;
    check("calc_wait", 32'(d0), 32'(6));

    // Loads while not idle are ignored.
    old5 = rom_m[5];
    img_we = 1'b1; img_addr = 6'd5; img_data = ~old5;
    tick();
    img_we = 1'b0;
    ifc.IROM_rd = 1'b1; ifc.IROM_A = 6'd5;
    tick();
    ifc.IROM_rd = 1'b0;

    // Random command stream (codes 1..15) with random calc busy lengths.
    for (int i = 0; i < 40; i++) begin
      calc_len = int'($urandom_range(4, 0));
      while (exp_q.size() >= 12) tick();
      push_cmd(4'($urandom_range(15, 1)));
      if ($urandom_range(1, 0) == 1) tick();
    end
    wait_drain("random", 600);

    // Write-back of all-0xFF frame.
    calc_len = 0;
    push_cmd(4'(CMD_WRITE));
    wait_cap("ff", 30);
    do_frame(1'b1, IMG_PIX, 1'b1);
    check_cap(37);
    check_cap(0);
    check_cap(63);

    // Fill the queue from idle: full after 16, 17th dropped and sticky.
    for (int i = 0; i < CQ_DEPTH; i++) begin
      check("cq_full_fill", 32'(cq_full), 32'(0));
      push_cmd(4'($urandom_range(15, 1)));
    end
    check("cq_full_at16", 32'(cq_full), 32'(exp_q.size() == CQ_DEPTH));
    check("overflow_before", 32'(overflow), 32'(ovf_m));
    push_cmd(4'($urandom_range(15, 1)));
    check("overflow_set", 32'(overflow), 32'(ovf_m));
    check("queue_model_len", 32'(exp_q.size()), 32'(CQ_DEPTH));
    // First issue cycle after start pops, so a push while full is accepted.
    start_pulse(s);
    c = 4'($urandom_range(15, 1));
    push_forced(c);
    check("cq_full_push_pop", 32'(cq_full), 32'(exp_q.size() == CQ_DEPTH));
    wait_drain("full", 200);
    check("cq_full_empty", 32'(cq_full), 32'(0));
    check("overflow_sticky", 32'(overflow), 32'(ovf_m));

    // Random frame from RUN.
    push_cmd(4'(CMD_WRITE));
    wait_cap("rand", 30);
    do_frame(1'b0, IMG_PIX, 1'b1);
    for (int i = 0; i < 6; i++) check_cap(int'($urandom_range(IMG_PIX - 1, 0)));

    // Reset in the middle of a capture, then a clean frame.
    push_cmd(4'(CMD_WRITE));
    start_pulse(s);
    wait_cap("pre_reset", 30);
    do_frame(1'b0, 10, 1'b0);
    chk_rom = 1'b0;
    apply_reset();
    check_reset("midcap");
    reset = 1'b1;
    tick();
    push_cmd(4'(CMD_WRITE));
    repeat (3) tick();
    check("idle_after_reset", 32'(exp_q.size()), 32'(1));
    start_pulse(s);
    wait_cap("post_reset", 30);
    do_frame(1'b0, IMG_PIX, 1'b1);
    for (int i = 0; i < 4; i++) check_cap(int'($urandom_range(IMG_PIX - 1, 0)));

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_host.md
# lcd_host

Host-side counterpart of the LCD image controller. It serves the controller's image-ROM reads from a loadable 64x8 store and issues queued 4-bit commands on the cmd/cmd_valid/busy handshake. It also captures the controller's 64-byte image-RAM write-back and reports a checksum. It sits between the testbench/system loader and the LCD controller, owning every pin the controller drives or samples.

## Interface
- CQ_DEPTH, 16, command queue depth (power of 2, >= 2)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- img_we  in  1  load strobe for ROM store (accepted only in state IDLE)
- img_addr  in  6  load address
- img_data  in  8  load data
- cq_push  in  1  enqueue command
- cq_data  in  4  command code
- cq_full  out  1  queue full
- start  in  1  one-cycle pulse; arms issuing
- cmd  out  4  command to controller
- cmd_valid  out  1  command strobe, one cycle per command
- busy  in  1  controller busy
- IROM_rd  in  1  controller read enable
- IROM_A  in  6  controller read address
- IROM_Q  out  8  read data
- IRAM_valid  in  1  controller write strobe
- IRAM_A  in  6  write address
- IRAM_D  in  8  write data
- done  in  1  controller frame-complete pulse
- cap_addr  in  6  capture readback address
- cap_data  out  8  capture readback data (combinational)
- frame_done  out  1  one-cycle pulse, capture complete
- checksum  out  14  sum of 64 captured bytes
- overflow  out  1  sticky: push while full

## Operation
- States: IDLE, RUN, GAP, CAPTURE, FIN.
- IDLE: img_we writes rom[img_addr]; start -> RUN. img_we outside IDLE ignored.
- IROM_Q = rom[IROM_A] combinationally when IROM_rd=1, else 8'h00. Served in every state.
- RUN: if busy=0 and queue non-empty, pop head, drive cmd=head, cmd_valid=1 for that cycle, go GAP. If head==0 (write-back), go CAPTURE instead. Empty queue: stay in RUN, cmd_valid=0.
- GAP: one mandatory cycle with cmd_valid=0 so busy from a calc command (5-7) is visible; then RUN.
- Codes 12-15 are forwarded unchanged; the controller treats them as no-ops.
- CAPTURE: each IRAM_valid writes cap[IRAM_A]=IRAM_D and adds IRAM_D into the accumulator. Issuing is blocked. On done: checksum <= accumulator (including a write in the same cycle), frame_done=1, go FIN.
- FIN: one cycle, then IDLE. The accumulator clears on entry to CAPTURE. Queue contents are preserved.
- Queue: push when full is dropped and sets overflow (cleared only by reset). Push and pop in the same cycle are both honored, including when the queue is full.
- cmd holds last issued value between strobes.

## Timing
- Reset values: cmd=0, cmd_valid=0, IROM_Q=0, cq_full=0, frame_done=0, checksum=0, overflow=0, state IDLE.
- Max issue rate: one command per 2 cycles when busy stays low (shift/rotate/mirror).
- Calc commands: busy samples high the cycle after cmd_valid; host waits for busy low.
- cmd_valid never asserts while busy=1 or during CAPTURE.
- Checksum width: 64x255 = 16320 fits 14 bits; no wrap.
- Reset mid-capture: state returns to IDLE and queue empties. ROM and capture array contents are unspecified.

## Structure
- Shared package lcd_pkg: CMD_WRITE=0, CMD_UP=1, CMD_DOWN=2, CMD_LEFT=3, CMD_RIGHT=4, CMD_MAX=5, CMD_MIN=6, CMD_AVG=7, CMD_ROT_CCW=8, CMD_ROT_CW=9, CMD_MIRROR_X=10, CMD_MIRROR_Y=11; IMG_PIX=64, PIX_W=8; host state enum.
- Sub-module lcd_cmd_fifo: synchronous FIFO, CQ_DEPTH x 4 bits, with push/pop/full/empty.

## Test plan
- Load rom[i]=i, controller reads IROM_A=0..63 with IROM_rd=1 -> IROM_Q=0..63 each cycle. With IROM_rd=0 -> IROM_Q=0.
- Queue {4,4,8}, start, busy=0 -> cmd_valid pulses exactly 2 cycles apart with cmd 4,4,8.
- Queue {7,1}, busy high for 5 cycles after the first strobe -> cmd 1 issued only after busy falls, never while busy=1.
- Push 17 commands without start -> cq_full=1 after 16, overflow=1, first 16 issued in order.
- Queue {0}, controller writes IRAM_D=0xFF to all 64 addresses then done -> checksum=16320, frame_done one-cycle pulse, cap_data(37)=0xFF.
- Reset asserted during CAPTURE -> outputs at reset values; a new start with fresh queue {0} completes normally.
